// File: rtl/ntt_ctrl.sv
// ntt_ctrl -- sequencing controller for the radix-2^RADIX_K1 NTT address path.
//
// Runs one complete transform (K stages x G groups = TOTAL AGU issues) per
// accepted start.  It generates the AGU enable and the read strobes derived
// from the AGU output-valid.  Butterfly-delayed write strobes come from a
// BF_LAT-deep pipe.  Ping-pong bank selects follow from the stage index.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start                 one-cycle transform request (honoured only in IDLE)
//   agu_out_en            AGU output-valid
//   agu_done_in           AGU end-of-transform flag
//   agu_enable            AGU enable, high for exactly TOTAL cycles per run
//   rd_en / wr_en         memory read / write strobes
//   rd_stage / wr_stage   stage index of the current read / write group
//   rd_bank / wr_bank     bank read / written this cycle
//   busy, done            run in progress / one-cycle completion pulse
//   err                   sticky AGU end-of-transform protocol error
//   state_dbg             current FSM state (IDLE=0, ISSUE=1, FLUSH=2, FIN=3)
//   cyc_cnt               busy-cycle counter, only with NTT_CTRL_PERF_EN
//
// Optional feature macro: NTT_CTRL_PERF_EN (adds cyc_cnt).
//
// Handshake: start is a pulse that is accepted only while busy=0.  Once it is
// accepted, busy stays high until and including the single done cycle.  A
// start seen while busy (including the done cycle) is dropped silently.
module ntt_ctrl #(
   parameter int D_WIDTH  = 32,
   parameter int LOGN     = 8,
   parameter int RADIX_K1 = 4,   // LOGN must be a multiple of RADIX_K1
   parameter int BF_LAT   = 4    // >= 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               agu_out_en,
   input  logic               agu_done_in,
   output logic               agu_enable,
   output logic               rd_en,
   output logic               wr_en,
   output logic [D_WIDTH-1:0] rd_stage,
   output logic [D_WIDTH-1:0] wr_stage,
   output logic               rd_bank,
   output logic               wr_bank,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         state_dbg
`ifdef NTT_CTRL_PERF_EN
   ,
   output logic [31:0]        cyc_cnt
`endif
);

   localparam int K     = LOGN / RADIX_K1;
   localparam int G_SH  = LOGN - RADIX_K1;        // log2(groups per stage)
   localparam int TOTAL = K << G_SH;
   localparam int CW    = $clog2(TOTAL + 1);      // holds TOTAL itself

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2, FIN = 2'd3} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       issue_cnt, rd_cnt, wr_cnt;
   logic                agu_done_exp;             // cycle after the final agu_enable
   logic                accept;
   logic [BF_LAT-1:0]   sr_en;
   logic [D_WIDTH-1:0]  sr_stage [BF_LAT];

   assign accept    = (state == IDLE) && start;
   assign state_dbg = state;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = ISSUE;
         ISSUE: if (issue_cnt == CW'(TOTAL - 1)) state_nxt = FLUSH;
         // Leave on the cycle of the last write so done lands right after it.
         FLUSH: if ((wr_en && (wr_cnt == CW'(TOTAL - 1))) || (wr_cnt == CW'(TOTAL)))
                   state_nxt = FIN;
         FIN:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   always_comb begin
      agu_enable = 1'b0;
      rd_en      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ISSUE: begin
            agu_enable = 1'b1;
            rd_en      = agu_out_en;
            busy       = 1'b1;
         end
         FLUSH: begin
            rd_en = agu_out_en;
            busy  = 1'b1;
         end
         FIN: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- counters and protocol check ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt    <= '0;
         rd_cnt       <= '0;
         wr_cnt       <= '0;
         err          <= 1'b0;
         agu_done_exp <= 1'b0;
      end else begin
         agu_done_exp <= agu_enable && (issue_cnt == CW'(TOTAL - 1));
         if (accept) begin
            issue_cnt <= '0;
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            err       <= 1'b0;
         end else begin
            if (agu_enable) issue_cnt <= issue_cnt + CW'(1);
            if (rd_en)      rd_cnt    <= rd_cnt + CW'(1);
            if (wr_en)      wr_cnt    <= wr_cnt + CW'(1);
            // agu_done_in must appear exactly in the expected cycle, never elsewhere.
            if (agu_done_in != agu_done_exp) err <= 1'b1;
         end
      end
   end

   // Stage = read count divided by groups per stage (upper bits of rd_cnt).
   assign rd_stage = D_WIDTH'(rd_cnt >> G_SH);
   assign rd_bank  = rd_stage[0];

   // ---------------- butterfly-latency pipe ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_en <= '0;
         for (int i = 0; i < BF_LAT; i++) sr_stage[i] <= '0;
      end else begin
         sr_en[0]    <= rd_en;
         sr_stage[0] <= rd_stage;
         for (int i = 1; i < BF_LAT; i++) begin
            sr_en[i]    <= sr_en[i-1];
            sr_stage[i] <= sr_stage[i-1];
         end
      end
   end

   assign wr_en    = sr_en[BF_LAT-1];
   assign wr_stage = sr_stage[BF_LAT-1];
   // Gated by wr_en so the idle/reset value is 0 rather than ~0.
   assign wr_bank  = wr_en & ~wr_stage[0];

`ifdef NTT_CTRL_PERF_EN
   // Counts busy cycles; holds after done until the next accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      cyc_cnt <= '0;
      else if (accept) cyc_cnt <= '0;
      else if (busy)   cyc_cnt <= cyc_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
module tb_ntt_ctrl;

   localparam int D_WIDTH  = 32;
   localparam int LOGN     = 8;
   localparam int RADIX_K1 = 4;
   localparam int BF_LAT   = 4;
   localparam int G        = 1 << (LOGN - RADIX_K1);
   localparam int K        = LOGN / RADIX_K1;
   localparam int TOTAL    = K * G;
   localparam int RUN_LEN  = TOTAL + 2 + BF_LAT;   // done cycle relative to start
   localparam int W        = 48;

   logic               clk, rst_n, start, agu_out_en, agu_done_in;
   logic               agu_enable, rd_en, wr_en, rd_bank, wr_bank, busy, done, err;
   logic [D_WIDTH-1:0] rd_stage, wr_stage;
   logic [1:0]         state_dbg;
`ifdef NTT_CTRL_PERF_EN
   logic [31:0]        cyc_cnt;
`endif

   ntt_ctrl #(.D_WIDTH(D_WIDTH), .LOGN(LOGN), .RADIX_K1(RADIX_K1), .BF_LAT(BF_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .agu_out_en(agu_out_en),
      .agu_done_in(agu_done_in), .agu_enable(agu_enable), .rd_en(rd_en), .wr_en(wr_en),
      .rd_stage(rd_stage), .wr_stage(wr_stage), .rd_bank(rd_bank), .wr_bank(wr_bank),
      .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
`ifdef NTT_CTRL_PERF_EN
      , .cyc_cnt(cyc_cnt)
`endif
   );

   // ---------------- clock / reset / cycle count ----------------
   int cyc = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AGU environment model ----------------
   int  agu_cnt;
   bit  agu_v, agu_d, force_done, suppress_done;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         agu_cnt <= 0; agu_v <= 1'b0; agu_d <= 1'b0;
      end else begin
         agu_v   <= agu_enable;
         agu_d   <= agu_enable && (agu_cnt == TOTAL - 1);
         agu_cnt <= agu_enable ? agu_cnt + 1 : 0;
      end
   end
   assign agu_out_en  = agu_v;
   assign agu_done_in = (agu_d & ~suppress_done) | force_done;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] rd_q[$], wr_q[$], done_q[$];
   int  n_cmp = 0, n_bad = 0;
   int  run_s = 0;
   bit  run_live = 1'b0;
   bit  err_exp = 1'b0;
   int  err_set_cyc = -1, err_clr_cyc = -1;

   function automatic logic [W-1:0] pack(int c, int stage, bit bank);
      logic [W-1:0] v;
      v        = '0;
      v[W-1:9] = (W-9)'(c);
      v[8:1]   = 8'(stage);
      v[0]     = bank;
      return v;
   endfunction

   task automatic check(string name, logic [W-1:0] got, logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic pop_check(string name, logic [W-1:0] got, inout logic [W-1:0] q[$]);
      if (q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL %s cycle %0d: got unexpected %h expected nothing", name, cyc, got);
      end else begin
         check(name, got, q.pop_front());
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle start pulse; the model decides whether it is accepted.
   task automatic pulse_start();
      int stage;
      bit acc;
      acc   = !(run_live && (cyc <= run_s + RUN_LEN));
      start = 1'b1;
      if (acc) begin
         run_s       = cyc;
         run_live    = 1'b1;
         err_clr_cyc = cyc + 1;
         for (int i = 0; i < TOTAL; i++) begin
            stage = i / G;
            rd_q.push_back(pack(cyc + 2 + i, stage, bit'(stage % 2)));
            wr_q.push_back(pack(cyc + 2 + BF_LAT + i, stage, bit'(1 - stage % 2)));
         end
         done_q.push_back(pack(cyc + RUN_LEN, 0, 1'b0));
      end
      tick(1);
      start = 1'b0;
   endtask

   task automatic force_pulse();
      force_done  = 1'b1;
      err_set_cyc = cyc + 1;
      tick(1);
      force_done  = 1'b0;
   endtask

   task automatic do_reset(int n);
      rst_n = 1'b0;
      rd_q.delete(); wr_q.delete(); done_q.delete();
      run_live = 1'b0; err_set_cyc = -1; err_clr_cyc = -1;
      force_done = 1'b0; suppress_done = 1'b0;
      tick(n);
      rst_n = 1'b1;
   endtask

   // Full run from the current cycle to the cycle after done.
   task automatic run_one(int spam_rel, int force_rel, bit suppress);
      int rel;
      suppress_done = suppress;
      pulse_start();
      if (suppress) err_set_cyc = run_s + TOTAL + 2;
      rel = cyc - run_s;
      while (rel <= RUN_LEN) begin
         if (rel == spam_rel)                    pulse_start();
         else if (rel == force_rel && !suppress) force_pulse();
         else                                    tick(1);
         rel = cyc - run_s;
      end
      suppress_done = 1'b0;
   endtask

   // ---------------- monitor ----------------
   int  m_rel;
   bit  exp_busy, exp_en;
   always @(negedge clk) begin
      if (!rst_n) begin
         err_exp = 1'b0;
         check("reset_outputs_zero",
               W'(|{agu_enable, rd_en, wr_en, rd_stage, wr_stage, rd_bank, wr_bank,
                    busy, done, err}), '0);
      end else begin
         if (cyc == err_clr_cyc) err_exp = 1'b0;
         if (cyc == err_set_cyc) err_exp = 1'b1;
         m_rel    = cyc - run_s;
         exp_busy = run_live && m_rel >= 1 && m_rel <= RUN_LEN;
         exp_en   = run_live && m_rel >= 1 && m_rel <= TOTAL;
         check("busy", W'(busy), W'(exp_busy));
         check("agu_enable", W'(agu_enable), W'(exp_en));
         check("err", W'(err), W'(err_exp));
         if (rd_en) pop_check("rd_event", pack(cyc, int'(rd_stage[7:0]), rd_bank), rd_q);
         if (wr_en) pop_check("wr_event", pack(cyc, int'(wr_stage[7:0]), wr_bank), wr_q);
         if (done)  pop_check("done_event", pack(cyc, 0, 1'b0), done_q);
`ifdef NTT_CTRL_PERF_EN
         if (done) check("cyc_cnt_at_done", W'(cyc_cnt), W'(RUN_LEN - 1));
         if (run_live && m_rel > RUN_LEN) check("cyc_cnt_hold", W'(cyc_cnt), W'(RUN_LEN));
`endif
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int gap, spam, frc;
      rst_n = 1'b0; start = 1'b0; force_done = 1'b0; suppress_done = 1'b0;
      tick(3);
      rst_n = 1'b1;
      tick(2);

      // Basic run then a back-to-back start the cycle after done.
      run_one(0, 0, 1'b0);
      // Second run with a start spammed mid-run (ignored).
      run_one(10, 0, 1'b0);
      // Start in the done cycle is ignored.
      run_one(RUN_LEN, 0, 1'b0);
      // agu_done_in forced high at relative cycle 15 -> sticky err.
      run_one(0, 15, 1'b0);
      tick(3);
      // Next accepted start clears err.
      run_one(0, 0, 1'b0);
      // Missing agu_done_in in the expected cycle -> err.
      run_one(0, 0, 1'b1);
      tick(2);
      // Stray agu_done_in while idle -> err, cleared by next run.
      force_pulse();
      tick(2);

      // Reset in the middle of a run, new start 25 cycles after the aborted one.
      pulse_start();
      tick(19);
      do_reset(2);
      tick(3);
      run_one(0, 0, 1'b0);

      // Randomised runs.
      for (int r = 0; r < 8; r++) begin
         gap  = $urandom_range(0, 4);
         spam = ($urandom_range(0, 1) == 1) ? $urandom_range(1, RUN_LEN) : 0;
         frc  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TOTAL) : 0;
         if (frc == spam) frc = 0;
         tick(gap);
         run_one(spam, frc, ($urandom_range(0, 5) == 0));
      end

      tick(4);
      check("rd_q_drained", W'(rd_q.size()), '0);
      check("wr_q_drained", W'(wr_q.size()), '0);
      check("done_q_drained", W'(done_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
